uart_tx_queue: RTL

- Transmit-side buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU peripheral bus into a FIFO and feeds them one at a time to the transmitter's tx_data/tx_enable inputs.
- Paces itself from the transmitter's tx_status, so software writes back-to-back without polling per byte.
- Sits between the CPU's UART data register write path and the transmitter.

---
 rtl/uart_tx_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO ahead of the UART transmitter, issuing one request per frame paced by tx_status.
// Optional macro UART_TXQ_CRLF_EN: a queued 8'h0A is preceded on the wire by an inserted 8'h0D.
module uart_tx_queue #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [7:0]       tx_data,
  output logic             tx_enable,
  input  logic             tx_status,
  output logic             busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_enable_q, tx_enable_d;
  logic              tx_status_q;
  logic              push, pop;
  logic [7:0]        head;
`ifdef UART_TXQ_CRLF_EN
  logic              crlf_sent_q, crlf_sent_d;
`endif

  assign head = mem_q[rd_ptr_q];

  // Next-state, pop decision and registered-output updates
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_enable_d = tx_enable_q;
    pop         = 1'b0;
`ifdef UART_TXQ_CRLF_EN
    crlf_sent_d = crlf_sent_q;
`endif
    // Full is judged on the pre-edge value, so a same-cycle pop cannot rescue a write
    push = wr_en && !full_q;

    case (state_q)
      IDLE: begin
        if (!empty_q && !tx_status_q) begin
          tx_enable_d = 1'b1;
          state_d     = REQ;
`ifdef UART_TXQ_CRLF_EN
          if (head == 8'h0A && !crlf_sent_q) begin
            tx_data_d   = 8'h0D;
            crlf_sent_d = 1'b1;
          end else begin
            tx_data_d   = head;
            pop         = 1'b1;
            crlf_sent_d = 1'b0;
          end
`else
          tx_data_d = head;
          pop       = 1'b1;
`endif
        end
      end
      REQ: begin
        // Hold the request until the slow-sampling transmitter acknowledges it
        if (tx_status_q) begin
          tx_enable_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (!tx_status_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        tx_enable_d = 1'b0;
      end
    endcase

    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);

    // A dropped write wins over a same-cycle clear
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
      tx_status_q <= 1'b0;
`ifdef UART_TXQ_CRLF_EN
      crlf_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      tx_data_q   <= tx_data_d;
      tx_enable_q <= tx_enable_d;
      tx_status_q <= tx_status;
`ifdef UART_TXQ_CRLF_EN
      crlf_sent_q <= crlf_sent_d;
`endif
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge sysclk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  assign tx_enable = tx_enable_q;
  assign busy      = (state_q != IDLE) || !empty_q;

endmodule
